// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin front end that shares one sequential multiplier
// among N requesters. Holds one operation in flight, with a watchdog that
// returns an error response if the multiplier never reports completion.
module mul_arbiter #(
  parameter int M   = 8,
  parameter int N   = 4,
  parameter int TMO = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_valid_i,
  input  logic [N*M-1:0]   req_a_i,
  input  logic [N*M-1:0]   req_b_i,
  output logic [N-1:0]     req_ready_o,
  output logic [N-1:0]     rsp_valid_o,
  output logic [2*M-1:0]   rsp_z_o,
  output logic             rsp_err_o,
  output logic             mul_start_o,
  output logic [M-1:0]     mul_a_o,
  output logic [M-1:0]     mul_b_o,
  input  logic             mul_done_i,
  input  logic [2*M-1:0]   mul_z_i,
  output logic             busy_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  rr_q, rr_d;
  logic [PW-1:0]  owner_q, owner_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   a_q, a_d, b_q, b_d;
  logic [2*M-1:0] res_q, res_d;
  logic           err_q, err_d;

  logic           gnt_found;
  logic [PW-1:0]  gnt_idx;
  logic [PW:0]    sum;
  logic [PW-1:0]  idx;

  // Winner search: first valid requester at or above rr_q, wrapping at N.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, rr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!gnt_found && req_valid_i[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  // Next-state and output decode; request strobes only exist in IDLE.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    err_d       = err_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_z_o     = '0;
    rsp_err_o   = 1'b0;
    mul_start_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        // ready is only raised on a valid requester, so it is a handshake
        if (gnt_found) begin
          req_ready_o[gnt_idx] = 1'b1;
          a_d     = req_a_i[gnt_idx*M +: M];
          b_d     = req_b_i[gnt_idx*M +: M];
          owner_d = gnt_idx;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        mul_start_o = 1'b1;
        cnt_d       = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        // completion takes priority over a watchdog expiry in the same cycle
        if (mul_done_i) begin
          res_d   = mul_z_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TMO-1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid_o[owner_q] = 1'b1;
        rsp_z_o   = res_q;
        rsp_err_o = err_q;
        rr_d      = (owner_q == PW'(N-1)) ? '0 : owner_q + 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mul_a_o = a_q;
  assign mul_b_o = b_q;
  assign busy_o  = (state_q != S_IDLE);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed and randomized checks of mul_arbiter against a
// round-robin / product model, with a latency-programmable multiplier stub.
module tb_mul_arbiter;
  localparam int M   = 8;
  localparam int N   = 4;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*M-1:0] req_a = '0, req_b = '0;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [2*M-1:0] rsp_z;
  logic           rsp_err, mul_start, busy;
  logic [M-1:0]   mul_a, mul_b;
  logic           mul_done;
  logic [2*M-1:0] mul_z;

  // multiplier stub: lat=0 never completes, lat=L raises done L+1 cycles after start
  logic           stub_done = 1'b0, spur_done = 1'b0;
  logic [2*M-1:0] stub_z = '0, spur_z = '0;
  logic [M-1:0]   sa = '0, sb = '0;
  int             stub_lat = 1;
  int             stub_cnt = 0;

  int checks = 0, errors = 0;
  int exp_ptr = 0;
  logic [M-1:0] oa [N];
  logic [M-1:0] ob [N];
  int w;

  assign mul_done = stub_done | spur_done;
  assign mul_z    = stub_z | spur_z;

  mul_arbiter #(.M(M), .N(N), .TMO(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_z_o(rsp_z), .rsp_err_o(rsp_err),
    .mul_start_o(mul_start), .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_done_i(mul_done),
    .mul_z_i(mul_z), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // multiplier stub
  always @(posedge clk) begin
    stub_done <= 1'b0;
    stub_z    <= '0;
    if (rst) stub_cnt <= 0;
    else if (mul_start) begin
      sa <= mul_a; sb <= mul_b; stub_cnt <= stub_lat;
    end else if (stub_cnt > 1) stub_cnt <= stub_cnt - 1;
    else if (stub_cnt == 1) begin
      stub_done <= 1'b1;
      stub_z    <= (2*M)'(sa) * (2*M)'(sb);
      stub_cnt  <= 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*M +: M] = oa[i];
      req_b[i*M +: M] = ob[i];
    end
  endtask

  // winner = valid requester at the smallest forward distance from the pointer
  function automatic int model_winner(input logic [N-1:0] v, input int ptr);
    int best = -1, bestd = N;
    for (int i = 0; i < N; i++)
      if (v[i] && ((i - ptr + N) % N) < bestd) begin
        best = i; bestd = (i - ptr + N) % N;
      end
    return best;
  endfunction

  // one full operation starting in an IDLE cycle; want_w<0 uses the model
  task automatic do_op(input int want_w, input int lat, output int gw);
    int d, expd;
    bit inr;
    logic [M-1:0] a, b;
    logic [2*M-1:0] ez;
    stub_lat = lat;
    gw = (want_w >= 0) ? want_w : model_winner(req_valid, exp_ptr);
    smp();
    chk("req_ready", req_ready, 64'(1) << gw);
    chk("busy_idle", busy, 0);
    a = oa[gw]; b = ob[gw];
    cyc(); smp();
    chk("mul_start", mul_start, 1);
    chk("launch_ops", {mul_a, mul_b}, {a, b});
    chk("launch_ready", req_ready, 0);
    chk("launch_busy", busy, 1);
    inr  = (lat >= 1 && lat <= TMO-1);
    expd = inr ? lat + 2 : TMO + 1;
    ez   = inr ? (2*M)'(a) * (2*M)'(b) : '0;
    d = 0;
    do begin
      cyc(); smp(); d++;
      if (rsp_valid == '0) begin
        chk("hold_ops", {mul_a, mul_b, req_ready, mul_start}, {a, b, 4'b0, 1'b0});
        chk("quiet_rsp", {rsp_z, rsp_err}, 0);
      end
    end while (rsp_valid == '0 && d < TMO + 8);
    chk("rsp_valid", rsp_valid, 64'(1) << gw);
    chk("latency", d, expd);
    chk("rsp_z", rsp_z, ez);
    chk("rsp_err", rsp_err, !inr);
    chk("resp_ops", {mul_a, mul_b}, {a, b});
    exp_ptr = (gw + 1) % N;
    cyc();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin oa[i] = '0; ob[i] = '0; end
    // reset state
    cyc(); cyc(); smp();
    chk("reset_outs", {req_ready, rsp_valid, rsp_z, rsp_err, mul_start, mul_a, mul_b, busy}, 0);
    cyc(); rst = 1'b0; smp();
    chk("post_reset_outs", {req_ready, rsp_valid, rsp_z, rsp_err, mul_start, mul_a, mul_b, busy}, 0);
    cyc();

    // round robin with all requesters held
    oa[0] = 8'd3;  ob[0] = 8'd4;
    oa[1] = 8'd10; ob[1] = 8'd20;
    oa[2] = 8'd7;  ob[2] = 8'd9;
    oa[3] = 8'd255; ob[3] = 8'd255;
    drive_ops();
    req_valid = 4'b1111;
    do_op(0, 2, w);
    do_op(1, 1, w);
    do_op(2, 4, w);
    do_op(3, 3, w);
    chk("prod_255", rsp_z, 0);
    do_op(0, 5, w);

    // reset mid-WAIT: pointer is 1, so the partial op goes to requester 1
    req_valid = 4'b0011;
    stub_lat = 0;
    smp();
    chk("pre_rst_ready", req_ready, 4'b0010);
    cyc(); cyc(); cyc(); cyc();
    smp();
    chk("pre_rst_busy", busy, 1);
    cyc(); rst = 1'b1; req_valid = '0;
    cyc(); smp();
    chk("midrst_outs", {req_ready, rsp_valid, rsp_z, rsp_err, mul_start, mul_a, mul_b, busy}, 0);
    cyc(); rst = 1'b0; smp();
    chk("midrst_after", {req_ready, rsp_valid, rsp_z, rsp_err, mul_start, mul_a, mul_b, busy}, 0);
    cyc();
    exp_ptr = 0;
    req_valid = 4'b0011;
    do_op(0, 2, w);

    // single request, requester 2, 12*13
    req_valid = 4'b0100;
    oa[2] = 8'd12; ob[2] = 8'd13; drive_ops();
    do_op(2, 3, w);

    // watchdog: no done ever, then next request accepted
    req_valid = 4'b0001;
    do_op(0, 0, w);
    // collision: done in the counter's last cycle
    req_valid = 4'b0010;
    oa[1] = 8'd201; ob[1] = 8'd77; drive_ops();
    do_op(1, TMO-1, w);
    // done arriving during RESP is ignored, watchdog already fired
    req_valid = 4'b1000;
    do_op(3, TMO, w);

    // spurious done while idle
    req_valid = '0;
    spur_done = 1'b1; spur_z = 16'hABCD;
    smp();
    chk("spur_busy", busy, 0);
    cyc(); spur_done = 1'b0; spur_z = '0;
    smp();
    chk("spur_outs", {rsp_valid, rsp_z, rsp_err, busy, mul_start}, 0);
    cyc();
    req_valid = 4'b1111;
    do_op(-1, 2, w);

    // randomized operations against the model
    for (int t = 0; t < 40; t++) begin
      int r, lat;
      logic [N-1:0] v;
      v = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        oa[i] = M'($urandom); ob[i] = M'($urandom);
      end
      drive_ops();
      req_valid = v;
      r = $urandom_range(0, 9);
      case (r)
        0: lat = 0;
        1: lat = TMO - 1;
        2: lat = TMO;
        default: lat = $urandom_range(1, 6);
      endcase
      do_op(-1, lat, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
